// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: fetch sequencer state encoding and default sizing shared by RTL and bench
package inst_fetch_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_CORE, DONE, ERR} state_t;
    localparam int MAX_LAT_DEF    = 10;
    localparam int ROM_DEPTH_DEF  = 1000;
    localparam int INST_COUNT_DEF = 1000;
endpackage

// File: rtl/inst_fetch_ctrl_lat_timer.sv
// lat_timer: wait-cycle counter that flags the last allowed cycle of a bounded wait
module lat_timer #(
    parameter int MAX_LAT = 10,
    parameter int W = $clog2(MAX_LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(MAX_LAT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetches ROM words, issues them to the core one beat at a time, follows the core's returned PC
module inst_fetch_ctrl import inst_fetch_pkg::*; #(
    parameter int ROM_DEPTH  = ROM_DEPTH_DEF,
    parameter int ROM_AW     = 10,
    parameter int MAX_LAT    = MAX_LAT_DEF,
    parameter int INST_COUNT = INST_COUNT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    input  logic              rom_rvalid,
    output logic              in_valid,
    output logic [31:0]       inst,
    input  logic              out_valid,
    input  logic [31:0]       inst_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              addr_err,
    output logic [CNT_W-1:0]  inst_cnt
);
    state_t state;
    logic expired, addr_bad, last, waiting, tmr_en;
    if (CNT_W < $clog2(INST_COUNT + 1)) begin : g_cnt_w_check
        $error("CNT_W too narrow for INST_COUNT");
    end
    assign addr_bad = (inst_addr[1:0] != 2'b00) || (inst_addr[31:2] >= 30'(ROM_DEPTH));
    assign last     = inst_cnt == CNT_W'(INST_COUNT - 1);
    assign waiting  = (state == WAIT_ROM) || (state == WAIT_CORE);
    assign tmr_en   = (state == WAIT_ROM) ? !rom_rvalid : (state == WAIT_CORE) ? !out_valid : 1'b0;
    // One timer serves both waits; it is held clear whenever no wait is in progress.
    lat_timer #(.MAX_LAT(MAX_LAT)) u_timer (
        .clk(clk), .rst(rst), .clr(!waiting), .en(tmr_en), .expired(expired)
    );
    // rom_addr doubles as the word-granular PC; only legal, in-range PCs are ever stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rom_req     <= 1'b0;
            rom_addr    <= '0;
            in_valid    <= 1'b0;
            inst        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            addr_err    <= 1'b0;
            inst_cnt    <= '0;
        end else begin
            rom_req  <= 1'b0;
            in_valid <= 1'b0;
            inst     <= '0;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state       <= FETCH;
                    rom_req     <= 1'b1;
                    rom_addr    <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    timeout_err <= 1'b0;
                    addr_err    <= 1'b0;
                    inst_cnt    <= '0;
                end
                FETCH: state <= WAIT_ROM;
                WAIT_ROM: if (rom_rvalid) begin
                    state    <= ISSUE;
                    in_valid <= 1'b1;
                    inst     <= rom_rdata;
                end else if (expired) begin
                    state       <= ERR;
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                end
                ISSUE: state <= WAIT_CORE;
                WAIT_CORE: if (out_valid) begin
                    if (addr_bad) begin
                        state    <= ERR;
                        busy     <= 1'b0;
                        addr_err <= 1'b1;
                    end else begin
                        rom_addr <= inst_addr[ROM_AW+1:2];
                        inst_cnt <= (inst_cnt == CNT_W'(INST_COUNT)) ? inst_cnt : inst_cnt + 1'b1;
                        state    <= last ? DONE : FETCH;
                        rom_req  <= !last;
                        busy     <= !last;
                        done     <= last;
                    end
                end else if (expired) begin
                    state       <= ERR;
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed and randomized runs against a program-level model of the fetch sequencer
module tb_inst_fetch_ctrl;
    import inst_fetch_pkg::*;
    localparam int ROM_AW = 10;
    localparam int ML     = MAX_LAT_DEF;
    localparam int DEPTH  = ROM_DEPTH_DEF;
    localparam int NINST  = 4;
    localparam int CNT_W  = 16;

    logic clk = 0, rst = 1, start = 0, rom_rvalid = 0, out_valid = 0;
    logic [31:0] rom_rdata = 0, inst_addr = 0;
    logic rom_req, in_valid, busy, done, timeout_err, addr_err;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0] inst;
    logic [CNT_W-1:0] inst_cnt;
    logic [31:0] rom [1024];
    int tests = 0, fails = 0, cyc = 0;

    inst_fetch_ctrl #(.ROM_DEPTH(DEPTH), .ROM_AW(ROM_AW), .MAX_LAT(ML), .INST_COUNT(NINST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_rdata(rom_rdata), .rom_rvalid(rom_rvalid), .in_valid(in_valid), .inst(inst),
        .out_valid(out_valid), .inst_addr(inst_addr), .busy(busy), .done(done),
        .timeout_err(timeout_err), .addr_err(addr_err), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic pulse_start;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Plays ROM and core for one instruction: ROM answers on wait cycle rw, core on wait cycle cw;
    // a wait beyond ML stays silent long enough for the DUT to give up.
    task automatic serve_inst(input int rw, input int cw, input logic [31:0] nxt,
                              output int addr, output logic [31:0] word, output logic iv);
        addr = -1; word = '0; iv = 0;
        for (int n = 0; n < 8 && !rom_req; n++) @(negedge clk);
        if (!rom_req) return;
        addr = int'(rom_addr);
        if (rw > ML) begin repeat (ML + 1) @(negedge clk); return; end
        repeat (rw) @(negedge clk);
        rom_rvalid = 1; rom_rdata = rom[addr];
        @(negedge clk);
        rom_rvalid = 0; rom_rdata = $urandom;
        iv = in_valid; word = inst;
        if (cw > ML) begin repeat (ML + 1) @(negedge clk); return; end
        repeat (cw) @(negedge clk);
        out_valid = 1; inst_addr = nxt;
        @(negedge clk);
        out_valid = 0; inst_addr = $urandom;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++; if ({rom_req, rom_addr, in_valid, inst, busy, done, timeout_err, addr_err, inst_cnt} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0", {rom_req, rom_addr, in_valid, inst, busy, done, timeout_err, addr_err, inst_cnt});
        end
        rst = 0;
        repeat (2) @(negedge clk);
        tests++; if ({rom_req, busy, done} !== 3'b000) begin
            fails++; $display("FAIL idle_quiet: got %b want 000", {rom_req, busy, done});
        end
    endtask

    task automatic test_straight;
        int a, c0; logic [31:0] w; logic v;
        pulse_start();
        tests++; if ({rom_req, busy} !== 2'b11) begin
            fails++; $display("FAIL start_to_req: got %b want 11", {rom_req, busy});
        end
        c0 = cyc;
        for (int i = 0; i < NINST; i++) begin
            serve_inst(1, 1, 32'((i + 1) * 4), a, w, v);
            tests++; if (a !== i) begin fails++; $display("FAIL straight_addr%0d: got %0d want %0d", i, a, i); end
            tests++; if (w !== rom[i] || v !== 1'b1) begin
                fails++; $display("FAIL straight_inst%0d: got %h/%b want %h/1", i, w, v, rom[i]);
            end
        end
        tests++; if (cyc - c0 !== 4 * NINST) begin fails++; $display("FAIL straight_cycles: got %0d want %0d", cyc - c0, 4 * NINST); end
        tests++; if ({done, busy, inst_cnt} !== {2'b10, CNT_W'(NINST)}) begin
            fails++; $display("FAIL straight_done: got done=%b busy=%b cnt=%0d want 1 0 %0d", done, busy, inst_cnt, NINST);
        end
        repeat (2) @(negedge clk);
        tests++; if ({done, rom_req, inst} !== {2'b10, 32'h0}) begin
            fails++; $display("FAIL done_sticky: got done=%b req=%b inst=%h want 1 0 0", done, rom_req, inst);
        end
    endtask

    task automatic test_branch;
        int a; logic [31:0] w; logic v;
        pulse_start();
        serve_inst(1, 1, 32'h40, a, w, v);
        serve_inst(1, 1, 32'h44, a, w, v);
        tests++; if (a !== 16 || w !== rom[16]) begin
            fails++; $display("FAIL branch_target: got addr=%0d inst=%h want 16 %h", a, w, rom[16]);
        end
        serve_inst(1, 1, 32'h48, a, w, v);
        tests++; if (a !== 17) begin fails++; $display("FAIL branch_follow: got %0d want 17", a); end
        serve_inst(2, 2, 32'h0, a, w, v);
        tests++; if ({done, inst_cnt} !== {1'b1, CNT_W'(NINST)}) begin
            fails++; $display("FAIL branch_done: got done=%b cnt=%0d want 1 %0d", done, inst_cnt, NINST);
        end
    endtask

    task automatic test_timeout;
        int a, reqs; logic [31:0] w; logic v;
        pulse_start();
        serve_inst(1, ML + 1, 32'h4, a, w, v);
        tests++; if ({timeout_err, addr_err, busy, done} !== 4'b1000) begin
            fails++; $display("FAIL core_timeout: got to/ae/busy/done=%b want 1000", {timeout_err, addr_err, busy, done});
        end
        reqs = 0;
        repeat (4) begin @(negedge clk); reqs += int'(rom_req); end
        tests++; if (reqs !== 0) begin fails++; $display("FAIL err_halts: got %0d requests want 0", reqs); end
        pulse_start();
        serve_inst(1, ML, 32'h4, a, w, v);
        tests++; if ({timeout_err, rom_req, inst_cnt} !== {2'b01, CNT_W'(1)}) begin
            fails++; $display("FAIL core_last_cycle: got to=%b req=%b cnt=%0d want 0 1 1", timeout_err, rom_req, inst_cnt);
        end
        serve_inst(ML + 1, 1, 32'h8, a, w, v);
        tests++; if ({timeout_err, busy, inst_cnt} !== {2'b10, CNT_W'(1)}) begin
            fails++; $display("FAIL rom_timeout: got to=%b busy=%b cnt=%0d want 1 0 1", timeout_err, busy, inst_cnt);
        end
        pulse_start();
        tests++; if ({timeout_err, inst_cnt} !== {1'b0, CNT_W'(0)}) begin
            fails++; $display("FAIL restart_clear: got to=%b cnt=%0d want 0 0", timeout_err, inst_cnt);
        end
        serve_inst(ML, 1, 32'h8, a, w, v);
        tests++; if ({timeout_err, w} !== {1'b0, rom[0]}) begin
            fails++; $display("FAIL rom_last_cycle: got to=%b inst=%h want 0 %h", timeout_err, w, rom[0]);
        end
        serve_inst(1, 1, 32'hC, a, w, v);
        serve_inst(1, 1, 32'h10, a, w, v);
        serve_inst(1, 1, 32'h14, a, w, v);
    endtask

    task automatic test_addr_err;
        int a, reqs; logic [31:0] w; logic v;
        logic [31:0] bad [2];
        bad[0] = 32'h6; bad[1] = 32'hFA0;
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            serve_inst(1, 1, bad[k], a, w, v);
            reqs = 0;
            repeat (4) begin @(negedge clk); reqs += int'(rom_req); end
            tests++; if ({addr_err, timeout_err, busy, inst_cnt} !== {3'b100, CNT_W'(0)} || reqs !== 0) begin
                fails++; $display("FAIL addr_err_%h: got ae/to/busy=%b cnt=%0d reqs=%0d want 100 0 0",
                                  bad[k], {addr_err, timeout_err, busy}, inst_cnt, reqs);
            end
        end
        pulse_start();
        serve_inst(1, 1, 32'hF9C, a, w, v);
        serve_inst(1, 1, 32'h0, a, w, v);
        tests++; if (a !== DEPTH - 1 || w !== rom[DEPTH - 1] || addr_err !== 1'b0) begin
            fails++; $display("FAIL addr_top_word: got addr=%0d inst=%h ae=%b want %0d %h 0", a, w, addr_err, DEPTH - 1, rom[DEPTH - 1]);
        end
        serve_inst(1, 1, 32'h4, a, w, v);
        serve_inst(1, 1, 32'h8, a, w, v);
    endtask

    task automatic test_start_busy;
        int a; logic [31:0] w; logic v;
        pulse_start();
        serve_inst(1, 1, 32'h8, a, w, v);
        start = 1;
        serve_inst(2, 3, 32'hC, a, w, v);
        start = 0;
        tests++; if (a !== 2 || inst_cnt !== CNT_W'(2)) begin
            fails++; $display("FAIL start_while_busy: got addr=%0d cnt=%0d want 2 2", a, inst_cnt);
        end
        serve_inst(1, 1, 32'h10, a, w, v);
        serve_inst(1, 1, 32'h14, a, w, v);
        tests++; if (a !== 4 || {done, inst_cnt} !== {1'b1, CNT_W'(NINST)}) begin
            fails++; $display("FAIL busy_run_done: got addr=%0d done=%b cnt=%0d want 4 1 %0d", a, done, inst_cnt, NINST);
        end
    endtask

    task automatic test_reset_mid;
        int a; logic [31:0] w; logic v;
        pulse_start();
        for (int i = 0; i < 3; i++) serve_inst(1, 1, 32'((i + 5) * 4), a, w, v);
        @(negedge clk);
        rom_rvalid = 1; rom_rdata = rom[rom_addr];
        @(negedge clk);
        rom_rvalid = 0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        tests++; if ({rom_req, rom_addr, in_valid, inst, busy, done, timeout_err, addr_err, inst_cnt} !== '0) begin
            fails++; $display("FAIL reset_mid_run: got %h want 0", {rom_req, rom_addr, in_valid, inst, busy, done, timeout_err, addr_err, inst_cnt});
        end
        @(negedge clk);
        rst = 0;
        pulse_start();
        tests++; if ({rom_req, rom_addr, inst_cnt} !== {1'b1, ROM_AW'(0), CNT_W'(0)}) begin
            fails++; $display("FAIL reset_restart: got req=%b addr=%0d cnt=%0d want 1 0 0", rom_req, rom_addr, inst_cnt);
        end
        for (int i = 0; i < NINST; i++) serve_inst(1, 1, 32'((i + 1) * 4), a, w, v);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL reset_rerun_done: got %b want 1", done); end
    endtask

    // Model: walk the program as the core would see it, stopping at the first late strobe or illegal PC.
    task automatic test_random;
        int rw[NINST], cw[NINST], exp_addr[NINST];
        logic [31:0] nx[NINST];
        int a, pc, n_exp, cnt_exp, k, word;
        bit to_exp, ae_exp;
        logic [31:0] w; logic v;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NINST; i++) begin
                rw[i] = ($urandom_range(0, 11) == 0) ? ML + 1 : int'($urandom_range(1, ML));
                cw[i] = ($urandom_range(0, 11) == 0) ? ML + 1 : int'($urandom_range(1, ML));
                k = int'($urandom_range(0, 9));
                word = int'($urandom_range(0, DEPTH - 1));
                nx[i] = (k == 0) ? 32'(word * 4 + int'($urandom_range(1, 3))) :
                        (k == 1) ? 32'(int'($urandom_range(DEPTH, 4 * DEPTH)) * 4) :
                        (k == 2) ? ($urandom | 32'h8000_0000) & ~32'h3 : 32'(word * 4);
            end
            pc = 0; n_exp = 0; cnt_exp = 0; to_exp = 0; ae_exp = 0;
            for (int i = 0; i < NINST; i++) begin
                exp_addr[i] = pc;
                n_exp = i + 1;
                if (rw[i] > ML || cw[i] > ML) begin to_exp = 1; break; end
                if (nx[i] % 4 != 0 || nx[i] / 4 >= DEPTH) begin ae_exp = 1; break; end
                pc = int'(nx[i] / 4);
                cnt_exp++;
            end
            pulse_start();
            tests++; if ({done, timeout_err, addr_err, inst_cnt} !== {3'b000, CNT_W'(0)}) begin
                fails++; $display("FAIL rnd%0d_clear: got %b cnt=%0d want 000 0", r, {done, timeout_err, addr_err}, inst_cnt);
            end
            for (int i = 0; i < n_exp; i++) begin
                serve_inst(rw[i], cw[i], nx[i], a, w, v);
                tests++; if (a !== exp_addr[i]) begin
                    fails++; $display("FAIL rnd%0d_addr%0d: got %0d want %0d", r, i, a, exp_addr[i]);
                end
                if (rw[i] <= ML) begin
                    tests++; if (w !== rom[exp_addr[i]] || v !== 1'b1) begin
                        fails++; $display("FAIL rnd%0d_inst%0d: got %h/%b want %h/1", r, i, w, v, rom[exp_addr[i]]);
                    end
                end
            end
            tests++; if ({done, timeout_err, addr_err, busy, inst_cnt} !== {cnt_exp == NINST, to_exp, ae_exp, 1'b0, CNT_W'(cnt_exp)}) begin
                fails++; $display("FAIL rnd%0d_end: got done/to/ae/busy=%b cnt=%0d want %b%b%b0 %0d",
                                  r, {done, timeout_err, addr_err, busy}, inst_cnt, cnt_exp == NINST, to_exp, ae_exp, cnt_exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        test_reset();
        test_straight();
        test_branch();
        test_timeout();
        test_addr_err();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
